// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequenced magnitude comparator.
// Consumers: cmp2_slice, cmp_seq_ctrl (optional build macro CMP_EARLY_EXIT_EN lives there).
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Comparison decision, one-hot once a comparison has completed
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_EQ   = 3'b010;
    localparam res_t RES_LT   = 3'b001;

    function automatic int unsigned nslice(input int unsigned width);
        return width / 2;
    endfunction

    // Index width, never below one bit so a single-slice build still has a counter
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned magnitude comparator, shared across all slice steps.
module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// MSB-first sequencing controller stepping one shared 2-bit comparator slice per clock.
// Build macro CMP_EARLY_EXIT_EN: when defined, RUN exits at the first unequal slice.
module cmp_seq_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    localparam int unsigned NSLICE = nslice(WIDTH);
    localparam int unsigned IDX_W  = idx_w(NSLICE);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    res_t             res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifndef CMP_EARLY_EXIT_EN
    res_t             dec_q, dec_d;
    logic             decided_q, decided_d;
`endif

    // Shared slice datapath: idx selects the operand bit pair
    logic [1:0] slice_a, slice_b;
    logic       s_gt, s_eq, s_lt;
    res_t       slice_res;

    assign slice_a = 2'(a_q >> (2 * idx_q));
    assign slice_b = 2'(b_q >> (2 * idx_q));

    cmp2_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .gt (s_gt),
        .eq (s_eq),
        .lt (s_lt)
    );

    assign slice_res = '{gt: s_gt, eq: s_eq, lt: s_lt};

    // Next-state and next-register logic; ena=0 leaves every register unchanged
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
`ifndef CMP_EARLY_EXIT_EN
        dec_d     = dec_q;
        decided_d = decided_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        idx_d   = IDX_TOP;
                        state_d = RUN;
`ifndef CMP_EARLY_EXIT_EN
                        dec_d     = RES_NONE;
                        decided_d = 1'b0;
`endif
                    end
                end
                RUN: begin
`ifdef CMP_EARLY_EXIT_EN
                    if (!s_eq || (idx_q == '0)) begin
                        res_d   = slice_res;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
`else
                    // First unequal slice is sticky; later slices cannot override it
                    if (!decided_q && !s_eq) begin
                        decided_d = 1'b1;
                        dec_d     = slice_res;
                    end
                    if (idx_q == '0) begin
                        res_d   = decided_q ? dec_q : slice_res;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
`endif
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= RES_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            dec_q     <= RES_NONE;
            decided_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifndef CMP_EARLY_EXIT_EN
            dec_q     <= dec_d;
            decided_q <= decided_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_gt_b = res_q.gt;
    assign a_eq_b = res_q.eq;
    assign a_lt_b = res_q.lt;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Scoreboard bench for cmp_seq_ctrl: directed cases plus randomized start/ena/operand traffic.
module tb_cmp_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    int vectors     = 0;
    int miscompares = 0;

    cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_lt_b (a_lt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the answer is plain unsigned ordering of the operands
    function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (x > y)       return 3'b100;
        else if (x == y) return 3'b010;
        else             return 3'b001;
    endfunction

    // Slice cycles until the decision: first differing bit pair from the top, or all pairs
    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
        for (int i = NSLICE - 1; i >= 0; i--) begin
            if (((x >> (2 * i)) & 3) != ((y >> (2 * i)) & 3)) return NSLICE - i;
        end
        return NSLICE;
`else
        return NSLICE;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int cyc);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (enabled edge %0d, t=%0t)", nm, act, exp, cyc, $time);
        end
    endtask

    // Scoreboard state, owned by the monitor
    logic [2:0] exp_q[$];
    logic [2:0] res_exp  = 3'b000;
    int         en_cyc   = 0;
    int         s_cyc    = -10;
    int         done_cyc = -10;

    initial begin
        logic             ena_e, rst_e, st_e;
        logic [WIDTH-1:0] a_e, b_e;
        forever begin
            @(posedge clk);
            ena_e = ena;
            rst_e = rst_n;
            st_e  = start;
            a_e   = a;
            b_e   = b;
            if (!rst_e) begin
                exp_q.delete();
                res_exp  = 3'b000;
                s_cyc    = -10;
                done_cyc = -10;
            end else if (ena_e) begin
                en_cyc++;
                // Accepted only in IDLE: nothing pending and not the DONE->IDLE edge
                if (st_e && exp_q.size() == 0 && en_cyc >= done_cyc + 2) begin
                    exp_q.push_back(model_res(a_e, b_e));
                    s_cyc    = en_cyc;
                    done_cyc = en_cyc + model_lat(a_e, b_e);
                end
            end
            #1;
            if (!rst_e) begin
                check("reset_busy", 32'(busy), 32'd0, en_cyc);
                check("reset_done", 32'(done), 32'd0, en_cyc);
                check("reset_result", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'd0, en_cyc);
            end else begin
                if (done && ena_e) begin
                    if (exp_q.size() == 0) check("done_without_request", 32'(exp_q.size()), 32'd1, en_cyc);
                    else res_exp = exp_q.pop_front();
                end
                check("done", 32'(done), 32'(en_cyc == done_cyc), en_cyc);
                check("busy", 32'(busy), 32'(en_cyc >= s_cyc && en_cyc < done_cyc), en_cyc);
                check("result", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(res_exp), en_cyc);
                if (exp_q.size() > 0 && en_cyc > done_cyc) begin
                    check("done_timeout", 32'(exp_q.size()), 32'd0, en_cyc);
                    exp_q.delete();
                end
            end
        end
    end

    task automatic run_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (NSLICE + 3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted before edge 2 of a run aborts it
        @(negedge clk);
        a = 8'hC3; b = 8'h43; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmp(8'hC3, 8'h43);
        run_cmp(8'h5A, 8'h5A);
        run_cmp(8'h12, 8'h13);

        // Start held high; operands changed while running
        @(negedge clk);
        a = 8'h01; b = 8'h00; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 8'h00;
                b = 8'hFF;
            end
        end
        start = 1'b0;
        repeat (NSLICE + 3) @(negedge clk);

        // Freeze for three cycles at edge 2 of a full run
        @(negedge clk);
        a = 8'h5A; b = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        repeat (NSLICE + 3) @(negedge clk);

        // Low slice truth table with equal upper bits
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] hi;
            hi = WIDTH'($urandom) & 8'hFC;
            run_cmp(hi | WIDTH'(i >> 2), hi | WIDTH'(i & 3));
        end

        // Random traffic with enable gaps
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            ena   = ($urandom % 6) != 0;
            start = ($urandom % 3) == 0;
            a     = WIDTH'($urandom);
            if ($urandom % 2) b = a ^ (WIDTH'(1) << ($urandom % WIDTH));
            else if ($urandom % 4 == 0) b = a;
            else b = WIDTH'($urandom);
        end
        ena   = 1'b1;
        start = 1'b0;
        repeat (NSLICE + 4) @(negedge clk);

        check("pending_at_end", 32'(exp_q.size()), 32'd0, en_cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
